// File: rtl/pipe_stage_ctl.sv
// pipe_stage_ctl: DEPTH back-to-back pipeline register stages carrying a
// datapath bundle and a control bundle, each tagged with a valid bit.
// Supports stall (hold), flush (squash to bubble), a live occupancy count
// and a saturating stall-cycle counter for the hazard unit and debug.
// A stage that holds a bubble always carries an all-zero control bundle,
// so no store, register write or halt can leak out of a squashed slot.
module pipe_stage_ctl #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 16,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          in_data,
  input  logic [CTRL_W-1:0]          in_ctrl,
  input  logic                       stall,
  input  logic                       flush,
  input  logic                       cnt_clr,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  output logic [CTRL_W-1:0]          out_ctrl,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic [CNT_W-1:0]           stall_cnt
);

  localparam int OCC_W = $clog2(DEPTH + 1);

  // Elaboration-time sanity checks on the configuration.
  if ((DEPTH < 1) || (DEPTH > 8)) begin : g_bad_depth
    $error("pipe_stage_ctl: DEPTH must be within 1..8");
  end
  if (DATA_W < 1) begin : g_bad_data_w
    $error("pipe_stage_ctl: DATA_W must be at least 1");
  end
  if (CTRL_W < 1) begin : g_bad_ctrl_w
    $error("pipe_stage_ctl: CTRL_W must be at least 1");
  end

  // Stage storage; index 0 is the entry stage, DEPTH-1 drives the outputs.
  logic [DEPTH-1:0]             valid_r;
  logic [DEPTH-1:0][CTRL_W-1:0] ctrl_r;
  logic [DEPTH-1:0][DATA_W-1:0] data_r;
  logic [CNT_W-1:0]             stall_cnt_r;
  logic [OCC_W-1:0]             occ_s;
  logic [CTRL_W-1:0]            in_ctrl_gated_s;

  // Gate the incoming control bundle so a bubble never enters with live control.
  always_comb begin
    in_ctrl_gated_s = {CTRL_W{1'b0}};
    if (in_valid) begin
      in_ctrl_gated_s = in_ctrl;
    end else begin
      in_ctrl_gated_s = {CTRL_W{1'b0}};
    end
  end

  // Stage registers: flush squashes, stall holds, otherwise shift by one stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_r <= '0;
      ctrl_r  <= '0;
      data_r  <= '0;
    end else if (flush) begin
      // Data is deliberately left untouched; only valid and control are squashed.
      valid_r <= '0;
      ctrl_r  <= '0;
    end else if (stall) begin
      valid_r <= valid_r;
      ctrl_r  <= ctrl_r;
      data_r  <= data_r;
    end else begin
      valid_r[0] <= in_valid;
      ctrl_r[0]  <= in_ctrl_gated_s;
      data_r[0]  <= in_data;
      for (int k = 1; k < DEPTH; k++) begin
        valid_r[k] <= valid_r[k-1];
        ctrl_r[k]  <= ctrl_r[k-1];
        data_r[k]  <= data_r[k-1];
      end
    end
  end

  // Stall-cycle counter: clear wins, then saturating increment on a real stall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (cnt_clr) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (stall && !flush && (stall_cnt_r != {CNT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + CNT_W'(1);
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  // Occupancy is the popcount of the stage valid bits.
  always_comb begin
    occ_s = {OCC_W{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      occ_s = occ_s + OCC_W'(valid_r[i]);
    end
  end

  assign out_valid = valid_r[DEPTH-1];
  assign out_ctrl  = ctrl_r[DEPTH-1];
  assign out_data  = data_r[DEPTH-1];
  assign occupancy = occ_s;
  assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_pipe_stage_ctl.sv
// Self-checking bench for pipe_stage_ctl: a queue of expected stage contents
// is updated as stimulus is applied and compared against the DUT outputs.
module tb_pipe_stage_ctl;

  localparam int DATA_W = 64;
  localparam int CTRL_W = 16;
  localparam int DEPTH  = 2;
  localparam int CNT_W  = 4;
  localparam int OCC_W  = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef struct packed {
    logic              v;
    logic [CTRL_W-1:0] c;
    logic [DATA_W-1:0] d;
  } ent_t;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              stall;
  logic              flush;
  logic              cnt_clr;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [OCC_W-1:0]  occupancy;
  logic [CNT_W-1:0]  stall_cnt;

  ent_t             q[$];
  logic [CNT_W-1:0] m_cnt;
  int               checks_cnt;
  int               fail_cnt;

  pipe_stage_ctl #(
    .DATA_W(DATA_W),
    .CTRL_W(CTRL_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ctrl  (in_ctrl),
    .stall    (stall),
    .flush    (flush),
    .cnt_clr  (cnt_clr),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ctrl (out_ctrl),
    .occupancy(occupancy),
    .stall_cnt(stall_cnt)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    ent_t z;
    z = '0;
    q.delete();
    for (int i = 0; i < DEPTH; i++) q.push_back(z);
    m_cnt = '0;
  endtask

  task automatic compare_all();
    ent_t last;
    int   occ;
    last = q[0];
    occ  = 0;
    foreach (q[i]) occ += int'(q[i].v);
    chk("out_valid", 64'(out_valid), 64'(last.v));
    chk("out_ctrl",  64'(out_ctrl),  64'(last.c));
    chk("out_data",  64'(out_data),  64'(last.d));
    chk("occupancy", 64'(occupancy), 64'(occ));
    chk("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
  endtask

  // One clock: update the model from the inputs seen at the edge, then compare.
  task automatic step();
    ent_t e;
    @(posedge clk);
    if (rst) begin
      if (cnt_clr) m_cnt = '0;
      else if (stall && !flush && (m_cnt != CNT_MAX)) m_cnt = m_cnt + 4'd1;
      if (flush) begin
        foreach (q[i]) begin
          e = q[i];
          e.v = 1'b0;
          e.c = '0;
          q[i] = e;
        end
      end else if (!stall) begin
        e.v = in_valid;
        e.c = in_valid ? in_ctrl : '0;
        e.d = in_data;
        q.push_back(e);
        void'(q.pop_front());
      end
    end
    #1;
    compare_all();
  endtask

  task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                       input logic s, input logic f, input logic cc);
    in_valid = v;
    in_data  = d;
    in_ctrl  = c;
    stall    = s;
    flush    = f;
    cnt_clr  = cc;
  endtask

  initial begin
    checks_cnt = 0;
    fail_cnt   = 0;
    rst = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    model_reset();

    // Reset state.
    #3;
    compare_all();
    #9 rst = 1'b1;

    // Latency: one instruction, then a bubble carrying live-looking control.
    drive(1'b1, 64'h1234, 16'h0005, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b0, 64'h9999, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    step();
    chk("lat_valid", 64'(out_valid), 64'd1);
    chk("lat_data",  64'(out_data),  64'h1234);
    chk("lat_ctrl",  64'(out_ctrl),  64'h0005);
    chk("lat_occ",   64'(occupancy), 64'd1);

    // Bubble gating: the in_valid=0 / ctrl=0xFFFF slot reaches the output.
    drive(1'b0, 64'h0, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    step();
    chk("bub_valid", 64'(out_valid), 64'd0);
    chk("bub_ctrl",  64'(out_ctrl),  64'h0000);

    // Stall: A in stage 1, B in stage 0, then hold three cycles with C presented.
    drive(1'b1, 64'hAAAA, 16'h0001, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 64'hBBBB, 16'h0002, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 64'hCCCC, 16'h0003, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step();
    chk("stall_data", 64'(out_data),  64'hAAAA);
    chk("stall_cnt3", 64'(stall_cnt), 64'd3);
    drive(1'b1, 64'hCCCC, 16'h0003, 1'b0, 1'b0, 1'b0);
    step();
    chk("rel_b", 64'(out_data), 64'hBBBB);
    drive(1'b0, 64'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    step();
    chk("rel_c", 64'(out_data), 64'hCCCC);

    // Flush beats stall.
    drive(1'b1, 64'h1111, 16'h00FF, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 64'h2222, 16'h00FF, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 64'h3333, 16'h00FF, 1'b1, 1'b1, 1'b0);
    step();
    chk("fl_valid", 64'(out_valid), 64'd0);
    chk("fl_ctrl",  64'(out_ctrl),  64'd0);
    chk("fl_occ",   64'(occupancy), 64'd0);
    chk("fl_data",  64'(out_data),  64'h1111);
    chk("fl_cnt",   64'(stall_cnt), 64'd3);

    // Counter saturation, then clear overriding a concurrent stall.
    drive(1'b0, 64'h0, 16'h0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step();
    chk("cnt_sat", 64'(stall_cnt), 64'd15);
    drive(1'b0, 64'h0, 16'h0, 1'b1, 1'b0, 1'b1);
    step();
    chk("cnt_clr", 64'(stall_cnt), 64'd0);

    // Random mix of all controls.
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), {$urandom, $urandom}, 16'($urandom),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 19) == 0));
      step();
    end

    // Asynchronous reset mid-stream with both stages full and a live count.
    drive(1'b1, 64'h5555, 16'h0011, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 64'h6666, 16'h0022, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 64'h7777, 16'h0033, 1'b1, 1'b0, 1'b0);
    step();
    chk("pre_rst_occ", 64'(occupancy), 64'd2);
    #2 rst = 1'b0;
    model_reset();
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_ctrl",  64'(out_ctrl),  64'd0);
    chk("arst_data",  64'(out_data),  64'd0);
    chk("arst_occ",   64'(occupancy), 64'd0);
    chk("arst_cnt",   64'(stall_cnt), 64'd0);
    #2 rst = 1'b1;
    drive(1'b1, 64'h8888, 16'h0044, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b0, 64'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    step();
    chk("post_rst_data", 64'(out_data), 64'h8888);

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end

endmodule
